// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
// Optional feature macro: JUMP_PREDECODE_EN (used by fetch_unit).
package fetch_pkg;

    localparam int         INSTR_W = 32;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    function automatic logic [31:0] jump_target(
        input logic [31:0] pc,
        input logic [31:0] ins
    );
        logic [31:0] pc4;
        pc4 = pc + 32'd4;
        return {pc4[31:28], ins[25:0], 2'b00};
    endfunction

    function automatic logic is_jump(input logic [31:0] ins);
        return (ins[31:26] == OP_J) || (ins[31:26] == OP_JAL);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage, flush, and simultaneous
// push/pop (also when full).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    wr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && !flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: fetch PC, credit-limited imem requests, prefetch queue.
// Define JUMP_PREDECODE_EN to resolve J/JAL as soon as they return.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    instr_pc,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int QW = XLEN + INSTR_W;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   q_count;
    logic [CW:0]     used;
    logic [QW-1:0]   q_rdata;
    logic            q_full, q_empty, q_push, q_pop;
    logic            req_fire, rsp_keep, jump_hit;

    assign rsp_keep = imem_rsp_valid && (drop_q == '0);
`ifdef JUMP_PREDECODE_EN
    assign jump_hit = rsp_keep && !redirect_valid
                      && is_jump(imem_rsp_data);
`else
    assign jump_hit = 1'b0;
`endif

    // Credits cover queued entries plus every outstanding request.
    assign used = {1'b0, q_count} + {1'b0, inflight_q};
    assign imem_req_valid = reset && !redirect_valid && !jump_hit
                            && (used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign q_push      = rsp_keep && !redirect_valid;
    assign instr_valid = !q_empty;
    assign q_pop       = instr_valid && instr_ready && !redirect_valid;
    assign {instr_pc, instr} = q_rdata;

    // Kept responses are sequential from the last redirect target,
    // so a running PC replaces a per-request PC queue.
    always_comb begin
        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
        fetch_pc_d = req_fire ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
        rsp_pc_d   = q_push ? rsp_pc_q + XLEN'(4) : rsp_pc_q;
        drop_d     = drop_q;
        if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            rsp_pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
            drop_d     = inflight_d;
        end
`ifdef JUMP_PREDECODE_EN
        else if (jump_hit) begin
            fetch_pc_d = jump_target(rsp_pc_q, imem_rsp_data);
            rsp_pc_d   = jump_target(rsp_pc_q, imem_rsp_data);
            drop_d     = inflight_d;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    sync_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (q_push),
        .wdata_i ({rsp_pc_q, imem_rsp_data}),
        .pop_i   (q_pop),
        .flush_i (redirect_valid),
        .rdata_o (q_rdata),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    always @(posedge clk) begin
        if (reset) begin
            assert (!(q_push && q_full && !q_pop));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit: memory model, expected
// instruction stream per redirect, and request-address model.
module tb_fetch_unit;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    mreq_t       mem_q[$];
    exp_t        exp_q[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    int          lat_max = 1;
    bit          mon_en = 1'b0;
    logic [31:0] gen_pc = '0;
    logic [31:0] req_model = '0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [31:0] pa = '0;

    fetch_unit #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic top_up();
        while (exp_q.size() < 16) begin
            exp_q.push_back('{gen_pc, memfn(gen_pc)});
            gen_pc += 32'd4;
        end
    endtask

    task automatic step();
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        top_up();
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        exp_q.delete();
        gen_pc = t & ~32'h3;
        top_up();
    endtask

    // Monitor: samples just before each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (mon_en && reset) begin
                if (redirect_valid) begin
                    check("no_req_on_redirect", imem_req_valid, 0);
                end else if (pv && !pr) begin
                    check("stall_valid", imem_req_valid, 1);
                    check("stall_addr", imem_req_addr, pa);
                end
                if (imem_req_valid && imem_req_ready) begin
                    check("req_addr", imem_req_addr, req_model);
                    mem_q.push_back('{imem_req_addr,
                        cyc + int'($urandom_range(1, lat_max))});
                    req_model += 32'd4;
                    acc_cnt++;
                end
                if (redirect_valid) begin
                    req_model = redirect_pc & ~32'h3;
                end
                if (instr_valid && instr_ready && !redirect_valid) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL exp_empty: got pc %0h expected none",
                                 instr_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("instr_pc", instr_pc, e.pc);
                        check("instr", instr, e.data);
                    end
                    pop_cnt++;
                end
                pv = imem_req_valid && !redirect_valid;
                pr = imem_req_ready;
                pa = imem_req_addr;
            end
        end
    end

    initial begin
        top_up();
        repeat (2) @(negedge clk);
        #2;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);

        step();
        reset          = 1'b1;
        mon_en         = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        repeat (10) step();
        #2;
        check("fill_accepts", acc_cnt, DEPTH);
        check("fill_req_valid", imem_req_valid, 0);
        check("fill_instr_valid", instr_valid, 1);
        check("fill_head_pc", instr_pc, 32'h0);

        lat_max = 3;
        step();
        instr_ready = 1'b1;
        repeat (5) step();
        step();
        do_redirect(32'h0000_0103);
        repeat (20) step();
        step();
        do_redirect(32'hFFFF_FFF9);
        repeat (20) step();

        for (int i = 0; i < 3000; i++) begin
            step();
            imem_req_ready = ($urandom_range(0, 9) < 7);
            instr_ready    = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 2))
                    0: do_redirect($urandom);
                    1: do_redirect(32'hFFFF_FFF0 | ($urandom & 32'hF));
                    default: do_redirect($urandom & 32'h3FF);
                endcase
            end
        end
        check("progress_pops", pop_cnt > 200, 1);
        check("progress_reqs", acc_cnt > 300, 1);

        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_req_valid", imem_req_valid, 0);
        check("async_instr_valid", instr_valid, 0);
        check("async_instr", instr, 0);
        check("async_instr_pc", instr_pc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
